// File: rtl/thermo_onehot_pipe_if.sv
// Stream bundle for the thermometer-to-one-hot pipeline: input word, result word,
// and error-counter control/status.
interface thermo_onehot_pipe_if #(
  parameter int N         = 15,
  parameter int ERR_CNT_W = 8
);
  localparam int CW = $clog2(N + 1);

  logic                 in_valid;
  logic                 in_ready;
  logic [N-1:0]         thermo;
  logic                 out_valid;
  logic                 out_ready;
  logic [N:0]           onehot;
  logic [CW-1:0]        count;
  logic                 err;
  logic                 err_clr;
  logic [ERR_CNT_W-1:0] err_count;

  modport master (
    output in_valid, thermo, out_ready, err_clr,
    input  in_ready, out_valid, onehot, count, err, err_count
  );

  modport slave (
    input  in_valid, thermo, out_ready, err_clr,
    output in_ready, out_valid, onehot, count, err, err_count
  );
endinterface

// File: rtl/thermo_onehot_pipe.sv
// Two-stage valid/ready thermometer-to-one-hot decoder with optional bubble repair,
// illegal-code flagging and a saturating error tally.
module thermo_onehot_pipe #(
  parameter int N          = 15,
  parameter int BUBBLE_FIX = 1,
  parameter int ERR_CNT_W  = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  thermo_onehot_pipe_if.slave    bus
);
  localparam int CW = $clog2(N + 1);
  localparam logic [ERR_CNT_W-1:0] ERR_MAX = '1;

  logic         v1, v2;
  logic         en1, en2;
  logic [N-1:0] c1;
  logic         raw_err1, legal1;

  logic [N+1:0] tp;
  logic [N-1:0] c_d;
  logic         raw_err_d, legal_d;

  logic [N+1:0] cp;
  logic [N:0]   onehot_d;
  logic [CW-1:0] count_d;

  logic [N:0]    onehot_q;
  logic [CW-1:0] count_q;
  logic          err_q;
  logic [ERR_CNT_W-1:0] err_count_q;

  assign en2          = !v2 || bus.out_ready;
  assign en1          = !v1 || en2;
  assign bus.in_ready = en1 && !rst;

  // Stage 1: padded code t[-1]=1, t[N]=0 lives at tp[0] / tp[N+1].
  always_comb begin
    tp        = {1'b0, bus.thermo, 1'b1};
    raw_err_d = 1'b0;
    legal_d   = 1'b1;
    c_d       = '0;
    for (int i = 0; i < N; i++) begin
      if (BUBBLE_FIX != 0)
        c_d[i] = (tp[i] & tp[i+1]) | (tp[i] & tp[i+2]) | (tp[i+1] & tp[i+2]);
      else
        c_d[i] = tp[i+1];
    end
    for (int i = 0; i < N - 1; i++) begin
      if (bus.thermo[i+1] && !bus.thermo[i]) raw_err_d = 1'b1;
      if (c_d[i+1] && !c_d[i])               legal_d   = 1'b0;
    end
  end

  // Stage 2: illegal (uncorrectable) codes decode to all zeros.
  always_comb begin
    cp       = {1'b0, c1, 1'b1};
    onehot_d = '0;
    count_d  = '0;
    if (legal1) begin
      for (int k = 0; k <= N; k++)
        onehot_d[k] = cp[k] & ~cp[k+1];
      for (int i = 0; i < N; i++)
        count_d = count_d + {{(CW-1){1'b0}}, c1[i]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1       <= 1'b0;
      c1       <= '0;
      raw_err1 <= 1'b0;
      legal1   <= 1'b1;
    end else if (en1) begin
      v1 <= bus.in_valid;
      if (bus.in_valid) begin
        c1       <= c_d;
        raw_err1 <= raw_err_d;
        legal1   <= legal_d;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v2       <= 1'b0;
      onehot_q <= '0;
      count_q  <= '0;
      err_q    <= 1'b0;
    end else if (en2) begin
      v2 <= v1;
      if (v1) begin
        onehot_q <= onehot_d;
        count_q  <= count_d;
        err_q    <= raw_err1 | !legal1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || bus.err_clr)
      err_count_q <= '0;
    else if (v2 && bus.out_ready && err_q && err_count_q != ERR_MAX)
      err_count_q <= err_count_q + 1'b1;
  end

  assign bus.out_valid = v2;
  assign bus.onehot    = onehot_q;
  assign bus.count     = count_q;
  assign bus.err       = err_q;
  assign bus.err_count = err_count_q;
endmodule

// File: tb/tb_thermo_onehot_pipe.sv
// Directed bench: three instances (bubble fix, strict, 4-bit error counter) share one stimulus.
module tb_thermo_onehot_pipe;
  logic clk = 1'b0;
  logic rst;
  logic in_valid, out_ready, err_clr;
  logic [14:0] thermo;
  int vecs = 0;
  int errs = 0;

  always #5 clk = ~clk;

  thermo_onehot_pipe_if #(.N(15), .ERR_CNT_W(8)) ifa ();
  thermo_onehot_pipe_if #(.N(15), .ERR_CNT_W(8)) ifb ();
  thermo_onehot_pipe_if #(.N(15), .ERR_CNT_W(4)) ifc ();

  assign ifa.in_valid = in_valid;  assign ifa.thermo = thermo;
  assign ifa.out_ready = out_ready; assign ifa.err_clr = err_clr;
  assign ifb.in_valid = in_valid;  assign ifb.thermo = thermo;
  assign ifb.out_ready = out_ready; assign ifb.err_clr = err_clr;
  assign ifc.in_valid = in_valid;  assign ifc.thermo = thermo;
  assign ifc.out_ready = out_ready; assign ifc.err_clr = err_clr;

  thermo_onehot_pipe #(.N(15), .BUBBLE_FIX(1), .ERR_CNT_W(8)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
  thermo_onehot_pipe #(.N(15), .BUBBLE_FIX(0), .ERR_CNT_W(8)) dut_b (.clk(clk), .rst(rst), .bus(ifb));
  thermo_onehot_pipe #(.N(15), .BUBBLE_FIX(1), .ERR_CNT_W(4)) dut_c (.clk(clk), .rst(rst), .bus(ifc));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vecs++;
    assert (got === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [15:0] oh,
                         input logic [3:0] cnt, input logic e);
    chk({tag, "_valid"}, 32'(ifa.out_valid), 32'(v));
    chk({tag, "_onehot"}, 32'(ifa.onehot), 32'(oh));
    chk({tag, "_count"}, 32'(ifa.count), 32'(cnt));
    chk({tag, "_err"}, 32'(ifa.err), 32'(e));
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; err_clr = 1'b0; thermo = '0;
    @(negedge clk);
    cyc();
    #1;
    chk_out("reset", 1'b0, 16'h0, 4'd0, 1'b0);
    chk("reset_errcnt", 32'(ifa.err_count), 32'd0);
    chk("reset_in_ready", 32'(ifa.in_ready), 32'd0);
    rst = 1'b0;
    #1;
    chk("post_reset_in_ready", 32'(ifa.in_ready), 32'd1);

    // Legal sweep, back to back, results two cycles after offer.
    for (int i = 0; i < 18; i++) begin
      if (i >= 2)
        chk_out($sformatf("sweep%0d", i - 2), 1'b1, 16'(32'd1 << (i - 2)), 4'(i - 2), 1'b0);
      in_valid = (i < 16);
      thermo   = (i < 16) ? 15'((32'd1 << i) - 1) : 15'd0;
      cyc();
    end
    chk("sweep_drained", 32'(ifa.out_valid), 32'd0);

    // Single bubble: repaired in dut_a, rejected in dut_b.
    in_valid = 1'b1; thermo = 15'b000000011101111;
    cyc();
    in_valid = 1'b0;
    cyc();
    chk_out("bubble_fix", 1'b1, 16'h0100, 4'd8, 1'b1);
    chk("bubble_strict_onehot", 32'(ifb.onehot), 32'h0);
    chk("bubble_strict_count", 32'(ifb.count), 32'd0);
    chk("bubble_strict_err", 32'(ifb.err), 32'd1);
    cyc();
    chk("bubble_errcnt", 32'(ifa.err_count), 32'd1);

    // Backpressure.
    out_ready = 1'b0; in_valid = 1'b1; thermo = 15'h0007;
    #1 chk("bp_ready0", 32'(ifa.in_ready), 32'd1);
    cyc();
    thermo = 15'h003F;
    #1 chk("bp_ready1", 32'(ifa.in_ready), 32'd1);
    cyc();
    thermo = 15'h01FF;
    for (int i = 0; i < 4; i++) begin
      #1 chk($sformatf("bp_stall_ready%0d", i), 32'(ifa.in_ready), 32'd0);
      chk_out($sformatf("bp_hold%0d", i), 1'b1, 16'h0008, 4'd3, 1'b0);
      cyc();
    end
    out_ready = 1'b1;
    #1 chk("bp_release_ready", 32'(ifa.in_ready), 32'd1);
    cyc();
    in_valid = 1'b0;
    chk_out("bp_second", 1'b1, 16'h0040, 4'd6, 1'b0);
    cyc();
    chk_out("bp_third", 1'b1, 16'h0200, 4'd9, 1'b0);
    cyc();
    chk("bp_drained", 32'(ifa.out_valid), 32'd0);

    // Saturation of the 4-bit counter.
    err_clr = 1'b1;
    cyc();
    err_clr = 1'b0;
    chk("clr_idle", 32'(ifc.err_count), 32'd0);
    in_valid = 1'b1; thermo = 15'h0005;
    for (int i = 0; i < 17; i++) cyc();
    in_valid = 1'b0;
    chk_out("sat_word", 1'b1, 16'h0004, 4'd2, 1'b1);
    cyc(); cyc(); cyc();
    chk("sat_errcnt_w4", 32'(ifc.err_count), 32'd15);
    chk("sat_errcnt_w8", 32'(ifa.err_count), 32'd17);
    in_valid = 1'b1;
    cyc();
    in_valid = 1'b0;
    cyc();
    chk("clr_pending_valid", 32'(ifc.out_valid), 32'd1);
    err_clr = 1'b1;
    cyc();
    err_clr = 1'b0;
    chk("clr_priority_w4", 32'(ifc.err_count), 32'd0);
    chk("clr_priority_w8", 32'(ifa.err_count), 32'd0);

    // Reset with both stages full.
    in_valid = 1'b1; thermo = 15'h0005;
    cyc();
    thermo = 15'h0003;
    cyc();
    thermo = 15'h000F;
    cyc();
    in_valid = 1'b0; out_ready = 1'b0;
    chk("pre_rst_errcnt", 32'(ifa.err_count), 32'd1);
    chk("pre_rst_valid", 32'(ifa.out_valid), 32'd1);
    rst = 1'b1;
    #1 chk("rst_in_ready_comb", 32'(ifa.in_ready), 32'd0);
    cyc();
    chk("rst_out_valid", 32'(ifa.out_valid), 32'd0);
    chk("rst_errcnt", 32'(ifa.err_count), 32'd0);
    chk("rst_in_ready", 32'(ifa.in_ready), 32'd0);
    rst = 1'b0;
    #1 chk("rst_release_ready", 32'(ifa.in_ready), 32'd1);
    in_valid = 1'b1; thermo = 15'h7FFF; out_ready = 1'b1;
    cyc();
    in_valid = 1'b0;
    chk("rst_lat1", 32'(ifa.out_valid), 32'd0);
    cyc();
    chk_out("rst_full", 1'b1, 16'h8000, 4'd15, 1'b0);
    cyc();
    chk("final_drain", 32'(ifa.out_valid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
